// File: rtl/pkt_con_rx.sv
// pkt_con_rx: 14-link slave-side receiver, qos-first round-robin arbiter feeding a FIFO.
// The head entry carries {qos, type, src, tgt, data, port}; there is no bypass in either direction.
module pkt_con_rx #(
    parameter int SRC_W  = 6,
    parameter int TGT_W  = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          x_vld,
    input  logic [6:0]          y_vld,
    input  logic [6:0]          x_qos,
    input  logic [6:0]          y_qos,
    input  logic [6:0]          x_type,
    input  logic [6:0]          y_type,
    input  logic [7*SRC_W-1:0]  x_src,
    input  logic [7*SRC_W-1:0]  y_src,
    input  logic [7*TGT_W-1:0]  x_tgt,
    input  logic [7*TGT_W-1:0]  y_tgt,
    input  logic [7*DATA_W-1:0] x_data,
    input  logic [7*DATA_W-1:0] y_data,
    output logic [6:0]          x_rdy,
    output logic [6:0]          y_rdy,
    output logic                out_vld,
    output logic                out_qos,
    output logic                out_type,
    output logic [SRC_W-1:0]    out_src,
    output logic [TGT_W-1:0]    out_tgt,
    output logic [DATA_W-1:0]   out_data,
    output logic [3:0]          out_port,
    input  logic                out_rdy
);
    localparam int EW = 6 + SRC_W + TGT_W + DATA_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [13:0] req, qos, typ, hi, cand, rdy;
    logic [14*SRC_W-1:0] src_all;
    logic [14*TGT_W-1:0] tgt_all;
    logic [14*DATA_W-1:0] data_all;
    logic [3:0] rr_ptr, win;
    logic found, full, push, pop;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    function automatic logic [3:0] wrap(input logic [4:0] s);
        return s >= 5'd14 ? 4'(s - 5'd14) : s[3:0];
    endfunction
    assign req      = {y_vld, x_vld};
    assign qos      = {y_qos, x_qos};
    assign typ      = {y_type, x_type};
    assign src_all  = {y_src, x_src};
    assign tgt_all  = {y_tgt, x_tgt};
    assign data_all = {y_data, x_data};
    assign hi       = req & qos;
    assign cand     = |hi ? hi : req;
    // Scan downward so the nearest candidate at or above rr_ptr is written last.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 13; k >= 0; k--) begin
            if (cand[wrap(5'(rr_ptr) + 5'(k))]) begin
                win   = wrap(5'(rr_ptr) + 5'(k));
                found = 1'b1;
            end
        end
    end
    assign full           = count == CW'(DEPTH);
    assign push           = found & ~full & ~rst;
    assign rdy            = push ? 14'(1) << win : '0;
    assign {y_rdy, x_rdy} = rdy;
    assign out_vld        = count != '0;
    assign pop            = out_vld & out_rdy;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                rr_ptr <= wrap(5'(win) + 5'd1);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {qos[win], typ[win], src_all[win*SRC_W +: SRC_W],
                                  tgt_all[win*TGT_W +: TGT_W], data_all[win*DATA_W +: DATA_W], win};
    end
    assign {out_qos, out_type, out_src, out_tgt, out_data, out_port} = mem[rd_ptr];
endmodule
